// File: rtl/mem_port_arbiter.sv
// Shares one single-ported, fixed-latency memory between instruction fetch and
// load/store, with data priority bounded so fetch is never starved.
module mem_port_arbiter #(
    parameter int unsigned MEM_LATENCY  = 2,
    parameter int unsigned MAX_DATA_RUN = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_ack,
    output logic [31:0] if_rdata,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic        d_ack,
    output logic [31:0] d_rdata,
    output logic        mem_en,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    output logic        busy
);

    localparam int unsigned CNT_W = 4;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t           state;
    logic [CNT_W-1:0] streak;
    logic [CNT_W-1:0] lat_cnt;
    logic             owner_d;
    logic             we_q;
    logic             data_wins;
    logic             unused_addr_bits;

    // Data wins a contested IDLE cycle unless fetch has waited out its run.
    always_comb begin
        data_wins = d_req && !(if_req && (streak == CNT_W'(MAX_DATA_RUN)));
    end

    // Byte-offset bits are dropped; alignment is the requester's problem.
    assign unused_addr_bits = ^{if_addr[1:0], d_addr[1:0]};

    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= IDLE;
            streak    <= '0;
            lat_cnt   <= '0;
            owner_d   <= 1'b0;
            we_q      <= 1'b0;
            if_ack    <= 1'b0;
            d_ack     <= 1'b0;
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            if_rdata  <= '0;
            d_rdata   <= '0;
            busy      <= 1'b0;
        end else begin
            if_ack <= 1'b0;
            d_ack  <= 1'b0;
            mem_en <= 1'b0;
            mem_we <= 1'b0;
            case (state)
                IDLE: begin
                    if (d_req || if_req) begin
                        state  <= ISSUE;
                        busy   <= 1'b1;
                        mem_en <= 1'b1;
                        if (data_wins) begin
                            owner_d   <= 1'b1;
                            we_q      <= d_we;
                            mem_we    <= d_we;
                            mem_addr  <= {d_addr[31:2], 2'b00};
                            mem_wdata <= d_wdata;
                            streak    <= if_req ? streak + CNT_W'(1) : '0;
                        end else begin
                            owner_d  <= 1'b0;
                            we_q     <= 1'b0;
                            mem_addr <= {if_addr[31:2], 2'b00};
                            streak   <= '0;
                        end
                    end
                end
                ISSUE: begin
                    state   <= WAIT;
                    lat_cnt <= CNT_W'(MEM_LATENCY);
                end
                WAIT: begin
                    lat_cnt <= lat_cnt - CNT_W'(1);
                    // Counter hits zero on this edge: read data is valid now.
                    if (lat_cnt == CNT_W'(1)) begin
                        state <= RESP;
                        if (owner_d) begin
                            d_ack <= 1'b1;
                            if (!we_q) begin
                                d_rdata <= mem_rdata;
                            end
                        end else begin
                            if_ack   <= 1'b1;
                            if_rdata <= mem_rdata;
                        end
                    end
                end
                RESP: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench: stimulus queues expected memory strobes and acks, a monitor
// on the falling edge models memory and checks everything the DUTs present.
`timescale 1ns/1ps
module tb_mem_port_arbiter;

    localparam int unsigned NI = 2;

    logic        clock = 1'b0;
    logic        reset;
    logic        if_req    [NI];
    logic [31:0] if_addr   [NI];
    logic        if_ack    [NI];
    logic [31:0] if_rdata  [NI];
    logic        d_req     [NI];
    logic        d_we      [NI];
    logic [31:0] d_addr    [NI];
    logic [31:0] d_wdata   [NI];
    logic        d_ack     [NI];
    logic [31:0] d_rdata   [NI];
    logic        mem_en    [NI];
    logic        mem_we    [NI];
    logic [31:0] mem_addr  [NI];
    logic [31:0] mem_wdata [NI];
    logic [31:0] mem_rdata [NI];
    logic        busy      [NI];

    always #5 clock = ~clock;

    // Instance 0 runs at L=2, instance 1 at L=3.
    for (genvar g = 0; g < NI; g++) begin : g_dut
        mem_port_arbiter #(.MEM_LATENCY((g == 0) ? 2 : 3), .MAX_DATA_RUN(4)) u_dut (
            .clock(clock), .reset(reset),
            .if_req(if_req[g]), .if_addr(if_addr[g]), .if_ack(if_ack[g]), .if_rdata(if_rdata[g]),
            .d_req(d_req[g]), .d_we(d_we[g]), .d_addr(d_addr[g]), .d_wdata(d_wdata[g]),
            .d_ack(d_ack[g]), .d_rdata(d_rdata[g]),
            .mem_en(mem_en[g]), .mem_we(mem_we[g]), .mem_addr(mem_addr[g]),
            .mem_wdata(mem_wdata[g]), .mem_rdata(mem_rdata[g]), .busy(busy[g])
        );
    end

    typedef struct {int idx; logic fetch; logic [31:0] rdata; int cyc;} ack_exp_t;
    typedef struct {int idx; logic we; logic [31:0] addr; logic [31:0] wdata; int cyc;} mem_exp_t;

    ack_exp_t ack_q[$];
    mem_exp_t mem_q[$];
    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int due     [NI];
    logic [31:0] rsp_val [NI];

    always @(posedge clock) cyc <= cyc + 1;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%h required=%h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    function automatic int lat(int i);
        return (i == 0) ? 2 : 3;
    endfunction

    function automatic logic [31:0] img(logic [31:0] a);
        case (a)
            32'h0000_0010: return 32'hDEAD_BEEF;
            32'h0000_0040: return 32'h2008_0001;
            default:       return a ^ 32'hC0DE_0000;
        endcase
    endfunction

    // Memory model and monitor.
    always @(negedge clock) begin
        for (int i = 0; i < NI; i++) begin
            mem_rdata[i] = (due[i] == cyc) ? rsp_val[i] : 32'hBAD0_BAD0;
            if (mem_we[i] && !mem_en[i]) chk("mem_we_unqualified", 32'(mem_we[i]), 32'd0);
            if (mem_en[i]) begin
                int j;
                if (!mem_we[i]) begin
                    due[i]     = cyc + lat(i);
                    rsp_val[i] = img(mem_addr[i]);
                end
                j = -1;
                for (int k = 0; k < mem_q.size(); k++)
                    if (j < 0 && mem_q[k].idx == i) j = k;
                if (j < 0) begin
                    chk("unexpected_mem_en", 32'(mem_en[i]), 32'd0);
                end else begin
                    chk("mem_we", 32'(mem_we[i]), 32'(mem_q[j].we));
                    chk("mem_addr", mem_addr[i], mem_q[j].addr);
                    if (mem_q[j].we) chk("mem_wdata", mem_wdata[i], mem_q[j].wdata);
                    chk("mem_en_cycle", 32'(cyc), 32'(mem_q[j].cyc));
                    mem_q.delete(j);
                end
            end
            if (if_ack[i] || d_ack[i]) begin
                int j;
                chk("dual_ack", 32'(if_ack[i] & d_ack[i]), 32'd0);
                j = -1;
                for (int k = 0; k < ack_q.size(); k++)
                    if (j < 0 && ack_q[k].idx == i) j = k;
                if (j < 0) begin
                    chk("unexpected_ack", 32'({if_ack[i], d_ack[i]}), 32'd0);
                end else begin
                    chk("ack_owner_fetch", 32'(if_ack[i]), 32'(ack_q[j].fetch));
                    chk("ack_rdata", if_ack[i] ? if_rdata[i] : d_rdata[i], ack_q[j].rdata);
                    chk("ack_cycle", 32'(cyc), 32'(ack_q[j].cyc));
                    ack_q.delete(j);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic wait_ack(int i, logic fetch);
        for (int n = 0; n < 40; n++) begin
            tick();
            if (fetch ? if_ack[i] : d_ack[i]) begin
                chk("busy_at_ack", 32'(busy[i]), 32'd1);
                return;
            end
        end
        checks++;
        errors++;
        $display("FAIL ack_timeout: actual=no ack required=ack within 40 cycles (inst %0d)", i);
    endtask

    task automatic data_txn(int i, logic we, logic [31:0] addr, logic [31:0] wdata,
                            logic [31:0] exp_rdata);
        int s;
        tick();
        s = cyc;
        chk("busy_idle", 32'(busy[i]), 32'd0);
        mem_q.push_back('{i, we, {addr[31:2], 2'b00}, wdata, s + 1});
        ack_q.push_back('{i, 1'b0, exp_rdata, s + lat(i) + 2});
        d_req[i] = 1'b1; d_we[i] = we; d_addr[i] = addr; d_wdata[i] = wdata;
        wait_ack(i, 1'b0);
        d_req[i] = 1'b0;
    endtask

    task automatic fetch_txn(int i, logic [31:0] addr, logic [31:0] exp_rdata);
        int s;
        tick();
        s = cyc;
        mem_q.push_back('{i, 1'b0, {addr[31:2], 2'b00}, 32'h0, s + 1});
        ack_q.push_back('{i, 1'b1, exp_rdata, s + lat(i) + 2});
        if_req[i] = 1'b1; if_addr[i] = addr;
        wait_ack(i, 1'b1);
        if_req[i] = 1'b0;
    endtask

    initial begin
        int s;
        for (int i = 0; i < NI; i++) begin
            if_req[i] = 0; if_addr[i] = 0; d_req[i] = 0; d_we[i] = 0;
            d_addr[i] = 0; d_wdata[i] = 0; due[i] = -1; rsp_val[i] = 0;
            mem_rdata[i] = 32'hBAD0_BAD0;
        end
        reset = 1'b1;
        repeat (3) tick();
        chk("rst_busy", 32'(busy[0]), 32'd0);
        chk("rst_mem_en", 32'(mem_en[0]), 32'd0);
        chk("rst_acks", 32'({if_ack[0], d_ack[0]}), 32'd0);
        chk("rst_mem_addr", mem_addr[0], 32'h0);
        chk("rst_mem_wdata", mem_wdata[0], 32'h0);
        chk("rst_d_rdata", d_rdata[0], 32'h0);
        chk("rst_if_rdata", if_rdata[0], 32'h0);
        reset = 1'b0;

        // Single load, store, then fetch with d_we floating high.
        data_txn(0, 1'b0, 32'h0000_0013, 32'h0, 32'hDEAD_BEEF);
        data_txn(0, 1'b1, 32'h0000_0020, 32'h1234_5678, 32'hDEAD_BEEF);
        d_we[0] = 1'b1;
        fetch_txn(0, 32'h0000_0040, 32'h2008_0001);
        d_we[0] = 1'b0;

        // Contention: D D D D F D D D D F, grants 5 cycles apart.
        tick();
        s = cyc;
        for (int k = 0; k < 10; k++) begin
            logic f;
            logic [31:0] a;
            f = ((k % 5) == 4);
            a = f ? 32'h0000_0200 : 32'h0000_0100;
            mem_q.push_back('{0, 1'b0, a, 32'h0, s + 1 + 5 * k});
            ack_q.push_back('{0, f, img(a), s + 4 + 5 * k});
        end
        d_req[0] = 1'b1; d_we[0] = 1'b0; d_addr[0] = 32'h0000_0100;
        if_req[0] = 1'b1; if_addr[0] = 32'h0000_0200;
        repeat (49) tick();
        chk("contention_last_ack", 32'(if_ack[0]), 32'd1);
        d_req[0] = 1'b0;
        if_req[0] = 1'b0;

        // Reset in cycle 2 of a load: aborted, no ack, rdata cleared.
        tick();
        tick();
        s = cyc;
        mem_q.push_back('{0, 1'b0, 32'h0000_0080, 32'h0, s + 1});
        d_req[0] = 1'b1; d_addr[0] = 32'h0000_0080;
        tick();
        tick();
        reset = 1'b1;
        d_req[0] = 1'b0;
        tick();
        chk("abort_busy", 32'(busy[0]), 32'd0);
        chk("abort_d_ack", 32'(d_ack[0]), 32'd0);
        chk("abort_mem_en", 32'(mem_en[0]), 32'd0);
        chk("abort_d_rdata", d_rdata[0], 32'h0);
        chk("abort_if_rdata", if_rdata[0], 32'h0);
        reset = 1'b0;
        repeat (6) tick();
        chk("abort_d_rdata_later", d_rdata[0], 32'h0);
        data_txn(0, 1'b0, 32'h0000_0044, 32'h0, img(32'h0000_0044));

        // Late arrival at L=3: fetch rises during WAIT of a load.
        tick();
        s = cyc;
        mem_q.push_back('{1, 1'b0, 32'h0000_0010, 32'h0, s + 1});
        ack_q.push_back('{1, 1'b0, 32'hDEAD_BEEF, s + 5});
        mem_q.push_back('{1, 1'b0, 32'h0000_0040, 32'h0, s + 7});
        ack_q.push_back('{1, 1'b1, 32'h2008_0001, s + 11});
        d_req[1] = 1'b1; d_we[1] = 1'b0; d_addr[1] = 32'h0000_0010;
        repeat (3) tick();
        if_req[1] = 1'b1; if_addr[1] = 32'h0000_0040;
        repeat (2) tick();
        chk("late_d_ack", 32'(d_ack[1]), 32'd1);
        d_req[1] = 1'b0;
        wait_ack(1, 1'b1);
        if_req[1] = 1'b0;

        repeat (6) tick();
        chk("ack_q_drained", 32'(ack_q.size()), 32'd0);
        chk("mem_q_drained", 32'(mem_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: actual=timeout required=finish before 200us");
        $fatal(1, "watchdog");
    end

endmodule
